// File: rtl/programmable_clock_divider_pkg.sv
// Shared definitions for the programmable clock divider.
// No ports. Provides:
//   mode_e        - output mode of a channel (pulse or 50 % square)
//   DEFAULT_WIDTH - default counter/divisor width
//   DEFAULT_DIV   - default divisor loaded into every channel at reset
//   ch_idx_w()    - width of a channel index for a given channel count
package programmable_clock_divider_pkg;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

  localparam int          DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DIV   = 100000000;

  // A single channel still needs a one-bit index port.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/programmable_clock_divider_if.sv
// Control/output bundle of the programmable clock divider.
// Signals:
//   En      - global count enable
//   Sync    - one-cycle restart of all channels
//   WrEn    - divisor/mode write strobe
//   WrCh    - target channel of a write
//   WrDiv   - new divisor
//   WrMode  - new mode (0 pulse, 1 square)
//   WrAck   - one-cycle acknowledge of an accepted write
//   OUTCLK  - divided output per channel
//   TICK    - terminal-count strobe per channel
// Modports: master (control logic side), slave (divider side).
interface programmable_clock_divider_if
  import programmable_clock_divider_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_CH = 2
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic              En;
  logic              Sync;
  logic              WrEn;
  logic [CH_W-1:0]   WrCh;
  logic [WIDTH-1:0]  WrDiv;
  logic              WrMode;
  logic              WrAck;
  logic [NUM_CH-1:0] OUTCLK;
  logic [NUM_CH-1:0] TICK;

  modport master (
    output En, Sync, WrEn, WrCh, WrDiv, WrMode,
    input  WrAck, OUTCLK, TICK
  );

  modport slave (
    input  En, Sync, WrEn, WrCh, WrDiv, WrMode,
    output WrAck, OUTCLK, TICK
  );

endinterface

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, active divisor/mode and a pending shadow
// that is only promoted at a terminal edge or on Sync, so a period is never
// cut short or stretched by a divisor change.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - count enable (low freezes counter and output, TICK 0)
//   sync      - restart counter/output and promote the shadow now
//   wr_en     - write strobe already decoded for this channel
//   wr_div    - divisor to place in the shadow
//   wr_mode   - mode to place in the shadow
//   outclk    - divided output (registered)
//   tick      - terminal-count strobe (registered)
module clock_divider_channel
  import programmable_clock_divider_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_div,
  input  mode_e            wr_mode,
  output logic             outclk,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  mode_e            pend_mode_q, pend_mode_d;
  logic             pend_vld_q, pend_vld_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;

  logic at_terminal;
  assign at_terminal = (cnt_q == div_q);

  always_comb begin
    cnt_d       = cnt_q;
    div_d       = div_q;
    mode_d      = mode_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    pend_vld_d  = pend_vld_q;
    out_d       = out_q;
    tick_d      = tick_q;

    if (sync) begin
      cnt_d  = '0;
      out_d  = 1'b0;
      tick_d = 1'b0;
      if (pend_vld_q) begin
        div_d      = pend_div_q;
        mode_d     = pend_mode_q;
        pend_vld_d = 1'b0;
      end
    end else if (en) begin
      if (at_terminal) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        // The output on the terminal edge still follows the mode that
        // governed the period just ending.
        out_d  = (mode_q == MODE_SQUARE) ? ~out_q : 1'b1;
        if (pend_vld_q) begin
          div_d      = pend_div_q;
          mode_d     = pend_mode_q;
          pend_vld_d = 1'b0;
        end
      end else begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (mode_q == MODE_PULSE) out_d = 1'b0;
      end
    end else begin
      tick_d = 1'b0;
    end

    // A write in the same cycle as a promotion lands after it, so it waits
    // for the next terminal edge (or Sync).
    if (wr_en) begin
      pend_div_d  = wr_div;
      pend_mode_d = wr_mode;
      pend_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      div_q       <= RST_DIV;
      mode_q      <= MODE_PULSE;
      pend_div_q  <= '0;
      pend_mode_q <= MODE_PULSE;
      pend_vld_q  <= 1'b0;
      out_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      pend_vld_q  <= pend_vld_d;
      out_q       <= out_d;
      tick_q      <= tick_d;
    end
  end

  assign outclk = out_q;
  assign tick   = tick_q;

endmodule

// File: rtl/programmable_clock_divider.sv
// Multi-channel run-time programmable clock/tick generator.
// Decodes the single write port onto NUM_CH divider channels and
// acknowledges accepted writes one cycle later.
// Ports:
//   CLK  - sole clock, rising edge
//   Rst  - asynchronous active-high reset
//   bus  - slave side of programmable_clock_divider_if
//          (En, Sync, WrEn, WrCh, WrDiv, WrMode in; WrAck, OUTCLK, TICK out)
module programmable_clock_divider
  import programmable_clock_divider_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               NUM_CH      = 2,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(programmable_clock_divider_pkg::DEFAULT_DIV)
) (
  input logic                        CLK,
  input logic                        Rst,
  programmable_clock_divider_if.slave bus
);

  localparam int              CH_W     = ch_idx_w(NUM_CH);
  localparam logic [CH_W:0]   NUM_CH_X = (CH_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] outclk_w;
  logic [NUM_CH-1:0] tick_w;
  logic              wr_ack_q, wr_ack_d;

  // Out-of-range channel numbers are silently dropped and never acked.
  always_comb begin
    wr_ack_d = bus.WrEn && ({1'b0, bus.WrCh} < NUM_CH_X);
  end

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) wr_ack_q <= 1'b0;
    else     wr_ack_q <= wr_ack_d;
  end

  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_sel[i] = bus.WrEn && (bus.WrCh == CH_W'(i));

    clock_divider_channel #(
      .WIDTH   (WIDTH),
      .RST_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (CLK),
      .rst     (Rst),
      .en      (bus.En),
      .sync    (bus.Sync),
      .wr_en   (wr_sel[i]),
      .wr_div  (bus.WrDiv),
      .wr_mode (mode_e'(bus.WrMode)),
      .outclk  (outclk_w[i]),
      .tick    (tick_w[i])
    );
  end

  assign bus.OUTCLK = outclk_w;
  assign bus.TICK   = tick_w;
  assign bus.WrAck  = wr_ack_q;

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Self-checking bench for programmable_clock_divider (3 channels, 8-bit,
// reset divisor 4). A behavioural model tracks each channel's position in
// its period and predicts OUTCLK/TICK/WrAck every cycle.
module tb_programmable_clock_divider;
  import programmable_clock_divider_pkg::*;

  localparam int               WIDTH  = 8;
  localparam int               NUM_CH = 3;
  localparam logic [WIDTH-1:0] DDIV   = 8'd4;

  logic CLK = 1'b0;
  logic Rst = 1'b1;

  programmable_clock_divider_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

  programmable_clock_divider #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEFAULT_DIV(DDIV)
  ) dut (
    .CLK (CLK),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: per channel, the phase within the current period,
  // the period length (divisor + 1), mode, and an optional queued setting.
  int              phase  [NUM_CH];
  int              divisor[NUM_CH];
  bit              square [NUM_CH];
  bit              queued [NUM_CH];
  int              q_div  [NUM_CH];
  bit              q_sq   [NUM_CH];
  bit [NUM_CH-1:0] m_out, m_tick;
  bit              m_ack;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      phase[c] = 0; divisor[c] = int'(DDIV); square[c] = 1'b0;
      queued[c] = 1'b0; q_div[c] = 0; q_sq[c] = 1'b0;
    end
    m_out = '0; m_tick = '0; m_ack = 1'b0;
  endfunction

  function automatic void model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.Sync) begin
        phase[c] = 0; m_out[c] = 1'b0; m_tick[c] = 1'b0;
        if (queued[c]) begin divisor[c] = q_div[c]; square[c] = q_sq[c]; queued[c] = 1'b0; end
      end else if (bus.En) begin
        if (phase[c] == divisor[c]) begin
          m_tick[c] = 1'b1;
          m_out[c]  = square[c] ? !m_out[c] : 1'b1;
          phase[c]  = 0;
          if (queued[c]) begin divisor[c] = q_div[c]; square[c] = q_sq[c]; queued[c] = 1'b0; end
        end else begin
          m_tick[c] = 1'b0;
          phase[c]  = phase[c] + 1;
          if (!square[c]) m_out[c] = 1'b0;
        end
      end else begin
        m_tick[c] = 1'b0;
      end
      if (bus.WrEn && int'(bus.WrCh) == c) begin
        q_div[c] = int'(bus.WrDiv); q_sq[c] = bus.WrMode; queued[c] = 1'b1;
      end
    end
    m_ack = bus.WrEn && (int'(bus.WrCh) < NUM_CH);
  endfunction

  task automatic step();
    @(posedge CLK);
    if (Rst) model_reset();
    else     model_step();
    #1;
  endtask

  task automatic set_write(input int ch, input int d, input bit mode);
    bus.WrEn = 1'b1; bus.WrCh = 2'(ch); bus.WrDiv = 8'(d); bus.WrMode = mode;
  endtask

  task automatic clear_strobes();
    bus.WrEn = 1'b0; bus.Sync = 1'b0;
  endtask

  task automatic test_reset();
    bus.En = 1'b0; bus.Sync = 1'b0; bus.WrEn = 1'b0;
    bus.WrCh = '0; bus.WrDiv = '0; bus.WrMode = 1'b0;
    Rst = 1'b1;
    step(); step();
    n_checks++;
    if ({bus.OUTCLK, bus.TICK, bus.WrAck} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_state: got %b/%b/%b want 000/000/0", bus.OUTCLK, bus.TICK, bus.WrAck);
    end
    Rst = 1'b0; bus.En = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      n_checks++;
      if (bus.OUTCLK !== m_out || bus.TICK !== m_tick || bus.WrAck !== m_ack) begin
        n_err++;
        $display("FAIL reset_run k=%0d: got %b/%b/%b want %b/%b/%b", k, bus.OUTCLK, bus.TICK, bus.WrAck, m_out, m_tick, m_ack);
      end
      n_checks++;
      if (bus.TICK[0] !== (k % 5 == 0) || bus.OUTCLK[0] !== (k % 5 == 0)) begin
        n_err++;
        $display("FAIL reset_pulse5 k=%0d: got tick %b out %b want %b", k, bus.TICK[0], bus.OUTCLK[0], (k % 5 == 0));
      end
    end
  endtask

  task automatic test_write_mid();
    step(); step();
    for (int k = 1; k <= 30; k++) begin
      if (k == 1) set_write(1, 2, 1'b1);
      step();
      clear_strobes();
      n_checks++;
      if (bus.OUTCLK !== m_out || bus.TICK !== m_tick || bus.WrAck !== m_ack) begin
        n_err++;
        $display("FAIL write_mid k=%0d: got %b/%b/%b want %b/%b/%b", k, bus.OUTCLK, bus.TICK, bus.WrAck, m_out, m_tick, m_ack);
      end
      n_checks++;
      if (bus.WrAck !== (k == 1)) begin
        n_err++;
        $display("FAIL write_ack k=%0d: got %b want %b", k, bus.WrAck, (k == 1));
      end
      n_checks++;
      if (bus.TICK[1] !== (k == 3 || (k > 3 && (k - 3) % 3 == 0))) begin
        n_err++;
        $display("FAIL ch1_period k=%0d: got %b want %b", k, bus.TICK[1], (k == 3 || (k > 3 && (k - 3) % 3 == 0)));
      end
    end
  endtask

  task automatic test_div0();
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) set_write(0, 0, 1'b0);
      if (k == 2) set_write(2, 0, 1'b1);
      if (k == 3) bus.Sync = 1'b1;
      step();
      clear_strobes();
      n_checks++;
      if (bus.OUTCLK !== m_out || bus.TICK !== m_tick || bus.WrAck !== m_ack) begin
        n_err++;
        $display("FAIL div0 k=%0d: got %b/%b/%b want %b/%b/%b", k, bus.OUTCLK, bus.TICK, bus.WrAck, m_out, m_tick, m_ack);
      end
      if (k >= 4) begin
        n_checks++;
        if (bus.OUTCLK[0] !== 1'b1 || bus.TICK[0] !== 1'b1 || bus.OUTCLK[2] !== (k % 2 == 0)) begin
          n_err++;
          $display("FAIL div0_shape k=%0d: got out0 %b tick0 %b out2 %b want 1 1 %b", k, bus.OUTCLK[0], bus.TICK[0], bus.OUTCLK[2], (k % 2 == 0));
        end
      end
    end
  endtask

  task automatic test_en_hold();
    logic [NUM_CH-1:0] held;
    held = '0;
    for (int k = 1; k <= 16; k++) begin
      bus.En = !(k >= 5 && k <= 11);
      if (k == 1) set_write(0, 4, 1'b0);
      if (k == 2) bus.Sync = 1'b1;
      step();
      clear_strobes();
      n_checks++;
      if (bus.OUTCLK !== m_out || bus.TICK !== m_tick || bus.WrAck !== m_ack) begin
        n_err++;
        $display("FAIL en_hold k=%0d: got %b/%b/%b want %b/%b/%b", k, bus.OUTCLK, bus.TICK, bus.WrAck, m_out, m_tick, m_ack);
      end
      if (k == 4) held = bus.OUTCLK;
      if (k >= 5 && k <= 11) begin
        n_checks++;
        if (bus.TICK !== '0 || bus.OUTCLK !== held) begin
          n_err++;
          $display("FAIL en_frozen k=%0d: got out %b tick %b want out %b tick 000", k, bus.OUTCLK, bus.TICK, held);
        end
      end
      if (k >= 12 && k <= 15) begin
        n_checks++;
        if (bus.TICK[0] !== (k == 14)) begin
          n_err++;
          $display("FAIL en_resume k=%0d: got tick0 %b want %b", k, bus.TICK[0], (k == 14));
        end
      end
    end
    bus.En = 1'b1;
  endtask

  task automatic test_sync_write();
    for (int k = 1; k <= 26; k++) begin
      if (k == 1) set_write(0, 9, 1'b0);
      if (k == 2) begin set_write(0, 3, 1'b0); bus.Sync = 1'b1; end
      if (k == 22) set_write(3, 1, 1'b1);
      step();
      clear_strobes();
      n_checks++;
      if (bus.OUTCLK !== m_out || bus.TICK !== m_tick || bus.WrAck !== m_ack) begin
        n_err++;
        $display("FAIL sync_write k=%0d: got %b/%b/%b want %b/%b/%b", k, bus.OUTCLK, bus.TICK, bus.WrAck, m_out, m_tick, m_ack);
      end
      if (k == 2) begin
        n_checks++;
        if (bus.OUTCLK !== '0 || bus.TICK !== '0 || bus.WrAck !== 1'b1) begin
          n_err++;
          $display("FAIL sync_edge: got %b/%b/%b want 000/000/1", bus.OUTCLK, bus.TICK, bus.WrAck);
        end
      end
      if (k > 2) begin
        n_checks++;
        if (bus.TICK[0] !== (k == 12 || k == 16 || k == 20 || k == 24)) begin
          n_err++;
          $display("FAIL sync_ch0_tick k=%0d: got %b want %b", k, bus.TICK[0], (k == 12 || k == 16 || k == 20 || k == 24));
        end
      end
      if (k == 22) begin
        n_checks++;
        if (bus.WrAck !== 1'b0) begin
          n_err++;
          $display("FAIL bad_ch_ack: got %b want 0", bus.WrAck);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 1; k <= 400; k++) begin
      bus.En = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0)
        set_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
      bus.Sync = ($urandom_range(0, 39) == 0);
      step();
      clear_strobes();
      n_checks++;
      if (bus.OUTCLK !== m_out || bus.TICK !== m_tick || bus.WrAck !== m_ack) begin
        n_err++;
        $display("FAIL random k=%0d: got %b/%b/%b want %b/%b/%b", k, bus.OUTCLK, bus.TICK, bus.WrAck, m_out, m_tick, m_ack);
      end
    end
    bus.En = 1'b1;
  endtask

  task automatic test_async_reset();
    set_write(1, 7, 1'b1);
    step();
    clear_strobes();
    n_checks++;
    if (bus.WrAck !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre_ack: got %b want 1", bus.WrAck);
    end
    #3 Rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({bus.OUTCLK, bus.TICK, bus.WrAck} !== 7'b0) begin
      n_err++;
      $display("FAIL arst_immediate: got %b/%b/%b want 000/000/0", bus.OUTCLK, bus.TICK, bus.WrAck);
    end
    step(); step();
    Rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      n_checks++;
      if (bus.OUTCLK !== m_out || bus.TICK !== m_tick || bus.WrAck !== m_ack) begin
        n_err++;
        $display("FAIL arst_run k=%0d: got %b/%b/%b want %b/%b/%b", k, bus.OUTCLK, bus.TICK, bus.WrAck, m_out, m_tick, m_ack);
      end
      n_checks++;
      if (bus.TICK !== ((k % 5 == 0) ? 3'b111 : 3'b000)) begin
        n_err++;
        $display("FAIL arst_cold k=%0d: got %b want %b", k, bus.TICK, ((k % 5 == 0) ? 3'b111 : 3'b000));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_mid();
    test_div0();
    test_en_hold();
    test_sync_write();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
